// File: rtl/ft_lockstep_voter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ft_lockstep_voter_if                                                     |
// | Bundles the lockstep cores' writeback streams and the voter's restore /  |
// | control outputs into one port.                                           |
// |   master : driven by the core side (we_i, addr_i, data_i, pc_i)          |
// |   slave  : used by the voter (drives we_o .. err_cnt_o)                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ft_lockstep_voter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CORES  = 2
);
  logic [NUM_CORES-1:0]            we_i;
  logic [NUM_CORES*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_CORES*DATA_WIDTH-1:0] data_i;
  logic [NUM_CORES*DATA_WIDTH-1:0] pc_i;
  logic                            we_o;
  logic [ADDR_WIDTH-1:0]           addr_o;
  logic [DATA_WIDTH-1:0]           data_o;
  logic [DATA_WIDTH-1:0]           pc_o;
  logic                            halt_o;
  logic                            resume_o;
  logic [NUM_CORES-1:0]            fault_core_o;
  logic [7:0]                      err_cnt_o;

  modport master (
    output we_i, addr_i, data_i, pc_i,
    input  we_o, addr_o, data_o, pc_o, halt_o, resume_o, fault_core_o, err_cnt_o
  );

  modport slave (
    input  we_i, addr_i, data_i, pc_i,
    output we_o, addr_o, data_o, pc_o, halt_o, resume_o, fault_core_o, err_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/ft_lockstep_voter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ft_lockstep_voter                                                        |
// | Compares the register-file write streams of NUM_CORES (2 = DMR,          |
// | 3 = TMR) lockstep cores, commits agreed writes to a shadow register file |
// | and checkpoints the PC. On an unrecoverable mismatch it halts the cores, |
// | streams the shadow file back and resumes them from the checkpointed PC.  |
// | Ports:                                                                   |
// |   clk_i  : clock                                                         |
// |   rst_ni : synchronous active-low reset                                  |
// |   bus    : ft_lockstep_voter_if.slave (core write streams in; restore    |
// |            strobe/address/data, pc_o, halt_o, resume_o, fault_core_o,    |
// |            err_cnt_o out)                                                |
// | Optional: define FT_ERR_COUNTER_EN to build the saturating fault counter |
// |           behind err_cnt_o; otherwise err_cnt_o is tied to zero.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ft_lockstep_voter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CORES  = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ft_lockstep_voter_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int TW    = 1 + ADDR_WIDTH + DATA_WIDTH;

  if (NUM_CORES != 2 && NUM_CORES != 3) begin : g_bad_cores
    $error("ft_lockstep_voter: NUM_CORES must be 2 or 3");
  end

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HALT    = 2'd1,
    S_RESTORE = 2'd2,
    S_RESUME  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic [DATA_WIDTH-1:0] r_spc;
  logic [NUM_CORES-1:0]  r_fault_core;

  // Per-channel tuple {we, addr, data}; addr/data are masked when we=0 so
  // idle channels always compare equal regardless of bus garbage.
  logic [TW-1:0]         w_tup [NUM_CORES];
  logic [DATA_WIDTH-1:0] w_pc  [NUM_CORES];

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_chan
    assign w_tup[k] = bus.we_i[k] ? {1'b1, bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH],
                                     bus.data_i[k*DATA_WIDTH +: DATA_WIDTH]} : '0;
    assign w_pc[k]  = bus.pc_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // w_agree: a committable tuple exists (unanimous, or a 2-of-3 majority).
  logic                  w_agree;
  logic [TW-1:0]         w_win_tup;
  logic [DATA_WIDTH-1:0] w_win_pc;
  logic [NUM_CORES-1:0]  w_minority;

  if (NUM_CORES == 2) begin : g_dmr
    // Core 1's PC is never a commit source in DMR.
    logic w_unused_pc;
    assign w_unused_pc = ^w_pc[1];
    assign w_agree     = (w_tup[0] == w_tup[1]);
    assign w_win_tup   = w_tup[0];
    assign w_win_pc    = w_pc[0];
    assign w_minority  = '0;
  end else begin : g_tmr
    logic w_eq01, w_eq02, w_eq12;
    always_comb begin
      w_eq01     = (w_tup[0] == w_tup[1]);
      w_eq02     = (w_tup[0] == w_tup[2]);
      w_eq12     = (w_tup[1] == w_tup[2]);
      w_agree    = w_eq01 | w_eq02 | w_eq12;
      w_win_tup  = w_tup[0];
      w_win_pc   = w_pc[0];
      w_minority = '0;
      // Equality is transitive, so exactly one pair matching means a single
      // outvoted core; the majority is represented by its lowest-index core.
      if (w_eq01 && !w_eq02) begin
        w_minority[2] = 1'b1;
      end else if (w_eq02 && !w_eq01) begin
        w_minority[1] = 1'b1;
      end else if (w_eq12 && !w_eq01) begin
        w_minority[0] = 1'b1;
        w_win_tup     = w_tup[1];
        w_win_pc      = w_pc[1];
      end
    end
  end

  logic                  w_run;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;

  assign w_run      = (r_state == S_RUN);
  assign w_commit   = w_run & w_agree & w_win_tup[TW-1];
  assign w_win_addr = w_win_tup[TW-2 -: ADDR_WIDTH];
  assign w_win_data = w_win_tup[DATA_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_RUN;
      r_index      <= '0;
      r_spc        <= '0;
      r_fault_core <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      // Index only advances while restoring; it naturally wraps to 0 on exit.
      r_index <= (r_state == S_RESTORE) ? r_index + ADDR_WIDTH'(1) : '0;
      if (w_commit) begin
        r_rf[w_win_addr] <= w_win_data;
        r_spc            <= w_win_pc;
      end
      if (w_run) begin
        r_fault_core <= r_fault_core | w_minority;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.we_o     = 1'b0;
    bus.addr_o   = '0;
    bus.data_o   = '0;
    bus.halt_o   = 1'b0;
    bus.resume_o = 1'b0;
    case (r_state)
      S_RUN: begin
        if (!w_agree) w_state_nxt = S_HALT;
      end
      S_HALT: begin
        bus.halt_o  = 1'b1;
        w_state_nxt = S_RESTORE;
      end
      S_RESTORE: begin
        bus.halt_o = 1'b1;
        bus.we_o   = 1'b1;
        bus.addr_o = r_index;
        bus.data_o = r_rf[r_index];
        if (&r_index) w_state_nxt = S_RESUME;
      end
      S_RESUME: begin
        bus.resume_o = 1'b1;
        w_state_nxt  = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign bus.pc_o         = r_spc;
  assign bus.fault_core_o = r_fault_core;

`ifdef FT_ERR_COUNTER_EN
  // One event per TMR outvote or per HALT entry; the two never coincide.
  logic       w_evt;
  logic [7:0] r_err_cnt;
  assign w_evt = w_run & (~w_agree | (|w_minority));
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if (w_evt && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
  assign bus.err_cnt_o = r_err_cnt;
`else
  assign bus.err_cnt_o = 8'd0;
`endif

endmodule
`default_nettype wire
